window_sequencer: RTL and testbench
===================================

// Module: window_sequencer
// PURPOSE
// - Control block for the 5x5 sliding-window datapath (column delay -> five-row line array -> row mux).
// - Tracks input raster position and drives the row write one-hot and row-mux rotation.
// - Runs the frame prime/run/flush sequence and flags which output windows touch the image border.
// - Sits beside the window datapath; consumes the same pixel-valid stream the datapath sees.
// PARAMETERS
// - WIDTH   420  active pixels per row (>= 5)
// - HEIGHT  240  active rows per frame (>= 5)
// - XW      9    x counter width, 2**XW >= WIDTH
// - YW      9    y counter width, 2**YW >= HEIGHT
// PORTS
// - clock        in   1   single clock, all logic rising-edge
// - reset        in   1   asynchronous, active-high; clears all state
// - sof          in   1   start of frame, qualified by validin, marks pixel (0,0)
// - validin      in   1   input pixel accepted this cycle
// - asel         out  5   one-hot row write select to line array
// - hsel         out  3   row-mux rotation index, 0..4
// - flush_en     out  1   datapath must inject zero pixel with valid this cycle
// - win_valid    out  1   window centred at (cx,cy) is produced this cycle
// - cx           out  XW  window centre column
// - cy           out  YW  window centre row
// - border       out  1   window includes out-of-image pixels (qualified by win_valid)
// - frame_done   out  1   one-cycle pulse after the last window of a frame
// - overrun      out  1   sticky: validin seen during FLUSH or sof mid-frame
// BEHAVIOUR
// - Reset values: asel=5'b00100, hsel=3'd2, state=IDLE, x=y=cx=cy=0; all 1-bit outputs 0.
// - Beat = (validin in PRIME/RUN) or (flush_en in FLUSH). All counters advance on beats only.
// - x counts 0..WIDTH-1 per beat, wraps to 0; y increments on x wrap.
// - On every x wrap: asel rotates left (10000 -> 00001); hsel = (hsel==4) ? 0 : hsel+1.
// - FSM states:
//   IDLE : validin&sof -> PRIME; that pixel is beat (0,0). validin without sof ignored.
//   PRIME: until 2*WIDTH+2 beats counted; the beat reaching that count -> RUN. No win_valid.
//   RUN  : win_valid=1 on each beat. Last input pixel (x=WIDTH-1,y=HEIGHT-1) -> FLUSH.
//   FLUSH: flush_en=1 every cycle for exactly 2*WIDTH+2 cycles; each is a beat with win_valid=1.
//          After final flush beat -> IDLE, frame_done=1 next cycle.
// - win_valid registered: asserted the cycle after the qualifying beat (latency 1); cx,cy,border valid with it.
// - cx/cy advance after each win_valid; cx wraps at WIDTH-1, cy increments on wrap.
// - Total win_valid per frame = WIDTH*HEIGHT exactly; first (0,0), last (WIDTH-1,HEIGHT-1).
// - validin in FLUSH: ignored, overrun set. sof during PRIME/RUN: overrun set, frame restarts
//   (counters, asel, hsel to reset values; state PRIME; that pixel is beat (0,0)).
// - sof on same cycle as frame_done: accepted, enters PRIME.
// - overrun cleared only by reset. Reset mid-frame: immediate return to reset values, no frame_done.
// - Counter compares exact; no arithmetic exceeds XW/YW bits (WIDTH-1, HEIGHT-1 fit by parameter rule).
// CONFIGURATION
// - BORDER_FLAG_EN defined: border = (cx<2)|(cx>WIDTH-3)|(cy<2)|(cy>HEIGHT-3), registered with cx/cy.
// - BORDER_FLAG_EN undefined: border tied 0; no compare logic synthesised; all else identical.
// TESTING (WIDTH=8, HEIGHT=6 unless noted)
// - Reset then idle: asel=00100, hsel=2, win_valid=0 forever with validin=0; validin w/o sof ignored.
// - Full frame, validin every cycle: 18 PRIME beats no win_valid; 48 win_valid total, 18 flush_en
//   cycles, first window (0,0), last (7,5), single frame_done pulse.
// - Row rotation: after 8 beats asel=01000,hsel=3; after 40 beats asel=00100,hsel=2 (5-row period).
// - validin 50% random gaps: identical cx/cy sequence and counts as gap-free frame.
// - sof at beat 30 mid-RUN: overrun=1, restart; next 48 win_valid complete normally.
// - BORDER_FLAG_EN on: border=1 for 40 of 48 windows (interior cx 2..5, cy 2..3 -> 8 windows 0); off: border=0.

Source files
------------

// File: rtl/window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : window_sequencer_if
// Description : Handshake/control bundle between the pixel source (master)
//               and the 5x5 window sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface window_sequencer_if #(
  parameter int XW = 9,
  parameter int YW = 9
) ();
  logic          sof;
  logic          validin;
  logic [4:0]    asel;
  logic [2:0]    hsel;
  logic          flush_en;
  logic          win_valid;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          border;
  logic          frame_done;
  logic          overrun;

  // Pixel source side: drives the stream, observes the sequencer status.
  modport master (
    output sof, validin,
    input  asel, hsel, flush_en, win_valid, cx, cy, border, frame_done, overrun
  );

  // Sequencer side.
  modport slave (
    input  sof, validin,
    output asel, hsel, flush_en, win_valid, cx, cy, border, frame_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : window_sequencer
// Description : Control block for the 5x5 sliding-window datapath. Tracks the
//               input raster, rotates the line-array write select and row-mux
//               index, runs the prime/run/flush frame sequence and emits the
//               window centre coordinates.
//               Optional feature macro: BORDER_FLAG_EN (border flag compare).
// Revision    : 1.0 - initial release
// ============================================================================
module window_sequencer #(
  parameter int WIDTH  = 420,
  parameter int HEIGHT = 240,
  parameter int XW     = 9,
  parameter int YW     = 9
) (
  input  logic              clock,
  input  logic              reset,
  window_sequencer_if.slave bus
);

  // Two full rows plus two pixels must be buffered before the first window
  // centre has its lower-right neighbour; the flush replays the same depth.
  localparam int               c_FILL      = 2 * WIDTH + 2;
  localparam int               c_CW        = $clog2(c_FILL);
  localparam logic [c_CW-1:0]  c_FILL_LAST = c_CW'(c_FILL - 1);
  localparam logic [XW-1:0]    c_X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]    c_Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [4:0]       c_ASEL_RST  = 5'b00100;
  localparam logic [2:0]       c_HSEL_RST  = 3'd2;
  localparam logic [2:0]       c_HSEL_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [c_CW-1:0]  r_cnt;
  logic [4:0]       r_asel;
  logic [2:0]       r_hsel;
  logic [XW-1:0]    r_cx;
  logic [YW-1:0]    r_cy;
  logic             r_win_valid;
  logic             r_border;
  logic             r_frame_done;
  logic             r_overrun;

  logic             w_sof;
  logic             w_restart;
  logic             w_beat;
  logic             w_win;
  logic             w_fill_done;
  logic             w_run_done;
  logic             w_frame_end;
  logic             w_overrun_set;
  logic             w_x_wrap;
  logic [XW-1:0]    w_cx_next;
  logic [YW-1:0]    w_cy_next;
  logic             w_border_next;

  assign w_sof    = bus.validin & bus.sof;
  assign w_x_wrap = (r_x == c_X_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, beat qualification and frame events.
  always_comb begin
    w_state_next  = r_state;
    w_restart     = 1'b0;
    w_beat        = 1'b0;
    w_win         = 1'b0;
    w_fill_done   = 1'b0;
    w_run_done    = 1'b0;
    w_frame_end   = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        // validin without sof is not part of any frame and is dropped.
        if (w_sof) begin
          w_restart    = 1'b1;
          w_state_next = S_PRIME;
        end
      end
      S_PRIME: begin
        if (w_sof) begin
          w_restart     = 1'b1;
          w_overrun_set = 1'b1;
          w_state_next  = S_PRIME;
        end else if (bus.validin) begin
          w_beat = 1'b1;
          if (r_cnt == c_FILL_LAST) begin
            w_fill_done  = 1'b1;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_sof) begin
          w_restart     = 1'b1;
          w_overrun_set = 1'b1;
          w_state_next  = S_PRIME;
        end else if (bus.validin) begin
          w_beat = 1'b1;
          w_win  = 1'b1;
          if (w_x_wrap && (r_y == c_Y_LAST)) begin
            w_run_done   = 1'b1;
            w_state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Every flush cycle is a synthetic zero-pixel beat; real input here
        // cannot be absorbed and is reported as overrun.
        w_beat        = 1'b1;
        w_win         = 1'b1;
        w_overrun_set = bus.validin;
        if (r_cnt == c_FILL_LAST) begin
          w_frame_end  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Raster position, line-array rotation and prime/flush depth counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_asel <= c_ASEL_RST;
      r_hsel <= c_HSEL_RST;
    end else if (w_restart) begin
      // The sof pixel itself is beat (0,0): load the post-beat values.
      r_x    <= XW'(1);
      r_y    <= '0;
      r_cnt  <= c_CW'(1);
      r_asel <= c_ASEL_RST;
      r_hsel <= c_HSEL_RST;
    end else begin
      if (w_beat) begin
        if (w_x_wrap) begin
          r_x    <= '0;
          r_y    <= r_y + 1'b1;
          r_asel <= {r_asel[3:0], r_asel[4]};
          r_hsel <= (r_hsel == c_HSEL_LAST) ? 3'd0 : r_hsel + 3'd1;
        end else begin
          r_x    <= r_x + 1'b1;
        end
      end
      if (w_fill_done || w_run_done || w_frame_end) begin
        r_cnt <= '0;
      end else if (w_beat && (r_state != S_RUN)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Window centre advances once per emitted window, raster order.
  always_comb begin
    w_cx_next = r_cx;
    w_cy_next = r_cy;
    if (w_restart) begin
      w_cx_next = '0;
      w_cy_next = '0;
    end else if (r_win_valid) begin
      if (r_cx == c_X_LAST) begin
        w_cx_next = '0;
        w_cy_next = r_cy + 1'b1;
      end else begin
        w_cx_next = r_cx + 1'b1;
      end
    end
  end

`ifdef BORDER_FLAG_EN
  localparam logic [XW-1:0] c_X_LO = XW'(2);
  localparam logic [XW-1:0] c_X_HI = XW'(WIDTH - 3);
  localparam logic [YW-1:0] c_Y_LO = YW'(2);
  localparam logic [YW-1:0] c_Y_HI = YW'(HEIGHT - 3);
  // A window reaches outside the image when its centre is within two
  // pixels of any edge.
  assign w_border_next = (w_cx_next < c_X_LO) | (w_cx_next > c_X_HI) |
                         (w_cy_next < c_Y_LO) | (w_cy_next > c_Y_HI);
`else
  assign w_border_next = 1'b0;
`endif

  // Registered window outputs and frame status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_win_valid  <= 1'b0;
      r_border     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cx         <= w_cx_next;
      r_cy         <= w_cy_next;
      r_win_valid  <= w_win;
      r_border     <= w_border_next;
      r_frame_done <= w_frame_end;
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.asel       = r_asel;
  assign bus.hsel       = r_hsel;
  assign bus.flush_en   = (r_state == S_FLUSH);
  assign bus.win_valid  = r_win_valid;
  assign bus.cx         = r_cx;
  assign bus.cy         = r_cy;
  assign bus.border     = r_border;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_sequencer
// Description : Self-checking bench for window_sequencer (8x6 image).
//               Windows are checked against a raster-order reference list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_sequencer;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int TXW = 4;
  localparam int TYW = 4;
  localparam int PW  = TXW + TYW + 1;
  localparam int NWIN = W * H;
  localparam int FILL = 2 * W + 2;

  logic clock = 1'b0;
  logic reset;

  window_sequencer_if #(.XW(TXW), .YW(TYW)) bus ();

  window_sequencer #(
    .WIDTH (W),
    .HEIGHT(H),
    .XW    (TXW),
    .YW    (TYW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation log, only ever appended to by the monitor.
  logic [PW-1:0] win_q[$];
  int flush_cnt = 0;
  int fd_cnt    = 0;
  int fd_win    = 0;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.win_valid) win_q.push_back({bus.cx, bus.cy, bus.border});
      if (bus.flush_en) flush_cnt++;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_win = win_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: window n of a frame is centred at raster position (n%W, n/W).
  function automatic logic [PW-1:0] win_word(input int x, input int y);
    logic [TXW-1:0] xv;
    logic [TYW-1:0] yv;
    logic           b;
    xv = TXW'(x);
    yv = TYW'(y);
`ifdef BORDER_FLAG_EN
    b = (x < 2) || (x > W - 3) || (y < 2) || (y > H - 3);
`else
    b = 1'b0;
`endif
    return {xv, yv, b};
  endfunction

  task automatic check_frame(input string tag, input int base, input int n);
    int bad;
    int nb;
    bad = 0;
    nb  = 0;
    for (int i = 0; i < n; i++) begin
      if (base + i >= win_q.size()) bad++;
      else if (win_q[base + i] !== win_word(i % W, i / W)) bad++;
      else if (win_q[base + i][0]) nb++;
    end
    check({tag, "_seq_errors"}, bad, 0);
    if (n == NWIN) begin
`ifdef BORDER_FLAG_EN
      check({tag, "_border_cnt"}, nb, 40);
`else
      check({tag, "_border_cnt"}, nb, 0);
`endif
    end
  endtask

  task automatic tick(input bit s, input bit v);
    bus.sof     = s;
    bus.validin = v;
    @(posedge clock);
    #1;
    bus.sof     = 1'b0;
    bus.validin = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    int w0, f0, d0;
    bit ok;
    int gaps;
    logic [PW-1:0] last_exp;

    bus.sof     = 1'b0;
    bus.validin = 1'b0;
    reset       = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    reset = 1'b0;

    // Reset state.
    check("rst_asel", bus.asel, 5'b00100);
    check("rst_hsel", bus.hsel, 3'd2);
    check("rst_win_valid", bus.win_valid, 1'b0);
    check("rst_cx", bus.cx, 0);
    check("rst_cy", bus.cy, 0);
    check("rst_flush_en", bus.flush_en, 1'b0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_border", bus.border, 1'b0);

    // validin without sof in IDLE is ignored.
    repeat (20) tick(1'b0, 1'b1);
    check("idle_wins", win_q.size(), 0);
    check("idle_asel", bus.asel, 5'b00100);
    check("idle_hsel", bus.hsel, 3'd2);
    check("idle_overrun", bus.overrun, 1'b0);

    // Frame A: validin every cycle.
    w0 = win_q.size(); f0 = flush_cnt; d0 = fd_cnt;
    tick(1'b1, 1'b1);
    repeat (7) tick(1'b0, 1'b1);                 // 8 beats
    check("rot8_asel", bus.asel, 5'b01000);
    check("rot8_hsel", bus.hsel, 3'd3);
    repeat (11) tick(1'b0, 1'b1);                // 19 beats
    check("prime_no_win", win_q.size() - w0, 0);
    repeat (21) tick(1'b0, 1'b1);                // 40 beats
    check("rot40_asel", bus.asel, 5'b00100);
    check("rot40_hsel", bus.hsel, 3'd2);
    repeat (8) tick(1'b0, 1'b1);                 // 48 beats
    wait_done(200, ok);
    check("a_done_in_time", ok, 1'b1);
    // Frame B sof lands on the frame_done cycle of frame A.
    tick(1'b1, 1'b1);
    last_exp = win_word(W - 1, H - 1);
    check("a_win_count", win_q.size() - w0, NWIN);
    check_frame("a", w0, NWIN);
    check("a_first", win_q[w0], win_word(0, 0));
    check("a_last", win_q[w0 + NWIN - 1], last_exp);
    check("a_flush_cycles", flush_cnt - f0, FILL);
    check("a_frame_done_pulses", fd_cnt - d0, 1);
    check("a_frame_done_after_last", fd_win - w0, NWIN);
    check("a_overrun", bus.overrun, 1'b0);

    // Frame B: remaining 47 beats with random gaps.
    w0 = win_q.size(); f0 = flush_cnt; d0 = fd_cnt;
    for (int i = 0; i < NWIN - 1; i++) begin
      gaps = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      repeat (gaps) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
    end
    wait_done(200, ok);
    check("b_done_in_time", ok, 1'b1);
    tick(1'b0, 1'b0);
    check("b_win_count", win_q.size() - w0, NWIN);
    check_frame("b", w0, NWIN);
    check("b_flush_cycles", flush_cnt - f0, FILL);
    check("b_frame_done_pulses", fd_cnt - d0, 1);
    check("b_overrun", bus.overrun, 1'b0);

    // Frame C: validin during FLUSH is ignored but flagged.
    w0 = win_q.size(); d0 = fd_cnt;
    tick(1'b1, 1'b1);
    repeat (NWIN - 1) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("c_flush_overrun", bus.overrun, 1'b1);
    wait_done(200, ok);
    check("c_done_in_time", ok, 1'b1);
    tick(1'b0, 1'b0);
    check("c_win_count", win_q.size() - w0, NWIN);
    check_frame("c", w0, NWIN);
    check("c_frame_done_pulses", fd_cnt - d0, 1);

    // Restart: sof on beat 30, mid-RUN.
    reset = 1'b1;
    repeat (2) tick(1'b0, 1'b0);
    reset = 1'b0;
    check("rst2_overrun", bus.overrun, 1'b0);
    w0 = win_q.size(); d0 = fd_cnt;
    tick(1'b1, 1'b1);
    repeat (28) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("restart_overrun", bus.overrun, 1'b1);
    check("restart_asel", bus.asel, 5'b00100);
    repeat (NWIN - 1) tick(1'b0, 1'b1);
    wait_done(200, ok);
    check("r_done_in_time", ok, 1'b1);
    tick(1'b0, 1'b0);
    check("r_win_count", win_q.size() - w0, 29 - FILL + NWIN);
    check_frame("r_pre", w0, 29 - FILL);
    check_frame("r", w0 + 29 - FILL, NWIN);
    check("r_frame_done_pulses", fd_cnt - d0, 1);

    // Reset mid-frame: immediate return to reset values, no frame_done.
    tick(1'b1, 1'b1);
    repeat (25) tick(1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("mrst_asel", bus.asel, 5'b00100);
    check("mrst_hsel", bus.hsel, 3'd2);
    check("mrst_win_valid", bus.win_valid, 1'b0);
    check("mrst_overrun", bus.overrun, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    w0 = win_q.size(); f0 = flush_cnt; d0 = fd_cnt;
    repeat (60) tick(1'b0, 1'b0);
    check("mrst_no_wins", win_q.size() - w0, 0);
    check("mrst_no_flush", flush_cnt - f0, 0);
    check("mrst_no_frame_done", fd_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
